// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller with deferred-flush FSM, sticky stall watchdog
// and optional per-stage stall counters (enabled by defining PIPE_CTRL_PERF_EN).
module pipe_hazard_ctrl #(
  parameter int NSTAGE = 5,
  parameter int CNT_W  = 16,
  parameter int WDOG   = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSTAGE-1:0]       stall_req,
  input  logic [NSTAGE-1:0]       flush_req,
  input  logic                    perf_clr,
  output logic [NSTAGE-1:0]       stall_ctrl,
  output logic [NSTAGE-1:0]       bubble_ctrl,
  output logic [NSTAGE-1:0]       flush_ctrl,
  output logic                    flush_pend,
  output logic                    stall_timeout,
  output logic [NSTAGE*CNT_W-1:0] stall_cnt
);

  localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [CNT_W-1:0] WDOG_C = CNT_W'(WDOG);

  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     pend_idx_q, pend_idx_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic              timeout_q, timeout_d;

  logic              stall_any, req_any, f_any, hold, defer, do_flush, do_stall;
  logic [IW-1:0]     s_idx, req_idx, f_idx;
  logic [NSTAGE-1:0] stall_c, bubble_c, flush_c;

  // Decode youngest-to-oldest requests into hold/bubble/kill controls
  always_comb begin
    stall_any = |stall_req;
    req_any   = |flush_req;
    hold      = (state_q == ST_HOLD);
    s_idx     = '0;
    req_idx   = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (stall_req[i]) begin
        s_idx = IW'(i);
      end else begin
        s_idx = s_idx;
      end
      if (flush_req[i]) begin
        req_idx = IW'(i);
      end else begin
        req_idx = req_idx;
      end
    end

    // A lower new flush index never displaces the held one
    f_any = req_any | hold;
    f_idx = hold ? pend_idx_q : '0;
    if (req_any && (!hold || (req_idx > pend_idx_q))) begin
      f_idx = req_idx;
    end else begin
      f_idx = f_idx;
    end

    defer    = f_any && stall_any && (s_idx > f_idx);
    do_flush = f_any && !defer;
    do_stall = stall_any && !do_flush;

    for (int k = 0; k < NSTAGE; k++) begin
      stall_c[k]  = do_stall && (k <= int'(s_idx));
      bubble_c[k] = do_stall && (k > 0) && ((k - 1) == int'(s_idx));
      flush_c[k]  = do_flush && (k < int'(f_idx));
    end

    state_d    = defer ? ST_HOLD : ST_RUN;
    pend_idx_d = defer ? f_idx : '0;

    if (|stall_c) begin
      wd_cnt_d = (wd_cnt_q == WDOG_C) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end else begin
      wd_cnt_d = '0;
    end
    timeout_d = timeout_q | (wd_cnt_d == WDOG_C);
  end

  // Control state and watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pend_idx_q <= '0;
      wd_cnt_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_idx_q <= pend_idx_d;
      wd_cnt_q   <= wd_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign stall_ctrl    = rst ? '0 : stall_c;
  assign bubble_ctrl   = rst ? '0 : bubble_c;
  assign flush_ctrl    = rst ? '0 : flush_c;
  assign flush_pend    = rst ? 1'b0 : (state_q == ST_HOLD);
  assign stall_timeout = rst ? 1'b0 : timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [NSTAGE-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturating per-stage stall counters; clear wins over increment
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      if (perf_clr) begin
        cnt_d[k] = '0;
      end else if (stall_c[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = rst ? '0 : cnt_q;
`else
  logic perf_clr_unused;
  assign perf_clr_unused = perf_clr;
  assign stall_cnt       = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (NSTAGE=5, WDOG=8).
module tb_pipe_hazard_ctrl;
  localparam int NS = 5;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   stall_req, flush_req;
  logic            perf_clr;
  logic [NS-1:0]   stall_ctrl, bubble_ctrl, flush_ctrl;
  logic            flush_pend, stall_timeout;
  logic [NS*CW-1:0] stall_cnt;
  int checks = 0;
  int failures = 0;
  logic [NS*CW-1:0] cnt_exp;

  pipe_hazard_ctrl #(.NSTAGE(NS), .CNT_W(CW), .WDOG(8)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .perf_clr(perf_clr), .stall_ctrl(stall_ctrl), .bubble_ctrl(bubble_ctrl),
    .flush_ctrl(flush_ctrl), .flush_pend(flush_pend),
    .stall_timeout(stall_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a falling edge, then settle before checks
  task automatic drive(input logic [NS-1:0] s, input logic [NS-1:0] f, input logic r);
    @(negedge clk);
    stall_req = s;
    flush_req = f;
    rst       = r;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_req = '0; flush_req = '0; perf_clr = 1'b0;

    drive(5'b00000, 5'b00000, 1'b1);
    chk("rst_stall", stall_ctrl, 5'b00000);
    chk("rst_pend", flush_pend, 1'b0);
    chk("rst_tmo", stall_timeout, 1'b0);
    chk("rst_cnt", stall_cnt, '0);
    drive(5'b00000, 5'b00000, 1'b0);
    chk("idle_pend", flush_pend, 1'b0);
    chk("idle_flush", flush_ctrl, 5'b00000);

    // single-cycle stall at stage 2
    drive(5'b00100, 5'b00000, 1'b0);
    chk("st2_stall", stall_ctrl, 5'b00111);
    chk("st2_bubble", bubble_ctrl, 5'b01000);
    chk("st2_flush", flush_ctrl, 5'b00000);
    drive(5'b00000, 5'b00000, 1'b0);
    chk("st2_release", stall_ctrl, 5'b00000);
`ifdef PIPE_CTRL_PERF_EN
    cnt_exp = {16'd0, 16'd0, 16'd1, 16'd1, 16'd1};
`else
    cnt_exp = '0;
`endif
    chk("st2_cnt", stall_cnt, cnt_exp);

    // plain flush from stage 3
    drive(5'b00000, 5'b01000, 1'b0);
    chk("fl3_flush", flush_ctrl, 5'b00111);
    chk("fl3_stall", stall_ctrl, 5'b00000);
    chk("fl3_bubble", bubble_ctrl, 5'b00000);
    drive(5'b00000, 5'b00000, 1'b0);
    chk("fl3_pend", flush_pend, 1'b0);
    chk("fl3_done", flush_ctrl, 5'b00000);

    // flush from stage 0 kills nothing
    drive(5'b00000, 5'b00001, 1'b0);
    chk("fl0_flush", flush_ctrl, 5'b00000);
    // stall younger than flush: flush wins
    drive(5'b00010, 5'b01000, 1'b0);
    chk("sle_flush", flush_ctrl, 5'b00111);
    chk("sle_stall", stall_ctrl, 5'b00000);
    chk("sle_bubble", bubble_ctrl, 5'b00000);
    drive(5'b00000, 5'b00000, 1'b0);
    chk("sle_pend", flush_pend, 1'b0);

    // deferred flush behind an oldest-stage stall
    drive(5'b10000, 5'b00100, 1'b0);
    chk("def_stall", stall_ctrl, 5'b11111);
    chk("def_bubble", bubble_ctrl, 5'b00000);
    chk("def_flush", flush_ctrl, 5'b00000);
    drive(5'b10000, 5'b00000, 1'b0);
    chk("def_pend1", flush_pend, 1'b1);
    chk("def_hold_flush", flush_ctrl, 5'b00000);
    drive(5'b10000, 5'b00000, 1'b0);
    chk("def_pend2", flush_pend, 1'b1);
    drive(5'b00000, 5'b00000, 1'b0);
    chk("def_release", flush_ctrl, 5'b00011);
    chk("def_rel_stall", stall_ctrl, 5'b00000);
    drive(5'b00000, 5'b00000, 1'b0);
    chk("def_pend_clr", flush_pend, 1'b0);
    chk("def_no_repeat", flush_ctrl, 5'b00000);

    // merging in HOLD: higher index replaces, lower does not
    drive(5'b10000, 5'b00100, 1'b0);
    drive(5'b10000, 5'b01000, 1'b0);
    chk("mrg_flush_sup", flush_ctrl, 5'b00000);
    drive(5'b10000, 5'b00010, 1'b0);
    chk("mrg_flush_sup2", flush_ctrl, 5'b00000);
    chk("mrg_pend", flush_pend, 1'b1);
    drive(5'b00000, 5'b00000, 1'b0);
    chk("mrg_release", flush_ctrl, 5'b00111);
    drive(5'b00000, 5'b00000, 1'b0);
    chk("mrg_pend_clr", flush_pend, 1'b0);

    // watchdog: 8 consecutive stalled cycles
    for (int i = 0; i < 8; i++) begin
      drive(5'b00001, 5'b00000, 1'b0);
      chk("wd_stall", stall_ctrl, 5'b00001);
      chk("wd_bubble", bubble_ctrl, 5'b00010);
      chk("wd_not_yet", stall_timeout, 1'b0);
    end
    drive(5'b00000, 5'b00000, 1'b0);
    chk("wd_trip", stall_timeout, 1'b1);
    drive(5'b00000, 5'b00000, 1'b0);
    chk("wd_sticky", stall_timeout, 1'b1);

    // reset in the middle of HOLD
    drive(5'b10000, 5'b00100, 1'b0);
    drive(5'b10000, 5'b00000, 1'b0);
    chk("rh_pend", flush_pend, 1'b1);
    drive(5'b10000, 5'b00000, 1'b1);
    chk("rh_stall0", stall_ctrl, 5'b00000);
    chk("rh_bubble0", bubble_ctrl, 5'b00000);
    chk("rh_pend0", flush_pend, 1'b0);
    chk("rh_tmo0", stall_timeout, 1'b0);
    chk("rh_cnt0", stall_cnt, '0);
    drive(5'b00000, 5'b00000, 1'b0);
    chk("rh_after_pend", flush_pend, 1'b0);
    chk("rh_after_flush", flush_ctrl, 5'b00000);
    chk("rh_after_tmo", stall_timeout, 1'b0);
    chk("rh_after_cnt", stall_cnt, '0);
    drive(5'b00000, 5'b00000, 1'b0);
    chk("rh_no_flush", flush_ctrl, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline stall/flush controller for the NPC core. It collects per-stage stall and flush requests from an N-stage in-order pipeline and generates hold, bubble and kill controls for every pipeline register. A flush that arrives while an older stage is stalled is latched and issued when that stall releases. The block also provides a stall watchdog and optional per-stage stall-cycle counters.

## Interface
- NSTAGE, 5, number of pipeline stages; index 0 = IF (youngest), NSTAGE-1 = oldest (WB side)
- CNT_W, 16, width of each stall-cycle counter
- WDOG, 1024, consecutive stalled cycles before the watchdog trips; must be ≥1 and < 2^CNT_W
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset (`ysyx22040228_RSTENA` = 1)
- stall_req  input  NSTAGE  bit i = stage i requests a stall this cycle
- flush_req  input  NSTAGE  bit j = stage j redirects; kill all stages younger than j
- perf_clr  input  1  synchronous clear of the stall counters
- stall_ctrl  output  NSTAGE  bit k = stage k holds its pipeline register
- bubble_ctrl  output  NSTAGE  bit k = insert NOP into stage k's input register
- flush_ctrl  output  NSTAGE  bit k = invalidate stage k's contents
- flush_pend  output  1  a deferred flush is held
- stall_timeout  output  1  sticky watchdog flag
- stall_cnt  output  NSTAGE*CNT_W  counter for stage k at bits [k*CNT_W +: CNT_W]; all zeros when perf is compiled out

## Operation
- s = highest index with stall_req set. f = highest index among flush_req bits and the pending index.
- Stall only (no f): stall_ctrl[s:0]=1. If s<NSTAGE-1, bubble_ctrl[s+1]=1. flush_ctrl=0.
- Flush with no stall, or s ≤ f: flush_ctrl[f-1:0]=1 (none if f=0). stall_ctrl=0 and bubble_ctrl=0. Pending is cleared.
- Flush with s > f: apply the stall outputs as above and suppress flush_ctrl. Latch f into pend_idx.
- FSM has two states:
  - RUN: default state.
  - HOLD: pend_idx is valid and flush_pend=1.
  - RUN→HOLD on a deferred flush.
  - HOLD→RUN in the first cycle where s ≤ pend_idx or no stall is present. That cycle issues flush_ctrl[pend_idx-1:0].
  - A new flush_req in HOLD merges into pend_idx by taking the maximum index. A lower index never replaces pend_idx.
- Watchdog:
  - wd_cnt increments on every cycle where stall_ctrl≠0 and clears on any cycle without a stall.
  - When wd_cnt reaches WDOG, stall_timeout is set. It stays set until rst.
  - wd_cnt saturates at WDOG.
- Counters (PIPE_CTRL_PERF_EN only): stall_cnt[k] increments when stall_ctrl[k]=1. The counters saturate at all-ones. perf_clr has priority over increment.

## Timing
- stall_ctrl, bubble_ctrl and flush_ctrl are combinational from the inputs and registered state. Latency to the consuming registers is 0 cycles.
- A deferred flush is issued in the same cycle the blocking stall drops, with no extra bubble cycle.
- flush_pend, stall_timeout and stall_cnt are registered and update 1 cycle after their cause.
- While rst=1, all outputs are forced to 0 combinationally.
- At the next edge with rst=1:
  - the FSM returns to RUN and pend_idx is cleared;
  - wd_cnt, stall_timeout and all counters are cleared.
- Reset during HOLD discards the pending flush.
- All requests are sampled every cycle; no handshake is required. Requesters may hold or pulse their signals.

## Configuration
- PIPE_CTRL_PERF_EN defined: the per-stage saturating stall counters and perf_clr are active.
- Not defined: no counter registers exist, stall_cnt is tied to 0 and perf_clr is ignored. Stall, flush and watchdog behaviour are identical in both builds.

## Test plan
All scenarios use NSTAGE=5 and WDOG=8.
- stall_req=00100 for 1 cycle -> stall_ctrl=00111, bubble_ctrl=01000, flush_ctrl=0. With PERF, stall_cnt[0..2]=1 on the next cycle.
- flush_req=01000 with stall_req=0 -> flush_ctrl=00111, stall_ctrl=0, flush_pend stays 0.
- stall_req=10000 held for 3 cycles plus a 1-cycle pulse flush_req=00100 in the first cycle -> the flush is suppressed and flush_pend=1. In the cycle stall_req drops, flush_ctrl=00011. flush_pend=0 the cycle after.
- In HOLD with pend_idx=2, pulse flush_req=01000 -> on release flush_ctrl=00111. A subsequent flush_req=00010 in HOLD leaves the release at 00111.
- stall_req=00001 held for 8 cycles -> stall_timeout=1 one cycle after the 8th. It stays 1 after the stall ends and clears only on rst.
- rst asserted mid-HOLD with counters nonzero -> outputs are 0 during rst. After release, flush_pend=0, stall_cnt=0 and no flush is issued.
